ov5640_init_seq: RTL and testbench
==================================

Name: ov5640_init_seq

Overview:
Sequencer that walks the OV5640 RGB init register ROM and issues one SCCB register write per entry to the SCCB write master.
- Sits between the init ROM (24-bit entries {reg_addr[15:0], data[7:0]}, one-cycle registered read) and the SCCB master.
- Inserts a power-up delay before the first write and a settle delay after any software-reset write.
- Reports busy, done and error status to the camera top level.

Parameters:
REG_NUM, 252, number of valid ROM entries (1..2**ADDR_WIDTH)
ADDR_WIDTH, 8, ROM address width
PWRUP_DELAY_CYC, 1000000, clk cycles waited after start before first fetch (20 ms at 50 MHz)
RESET_DELAY_CYC, 250000, clk cycles waited after a software-reset write completes (5 ms at 50 MHz)
MAX_RETRY, 3, extra attempts per entry on NACK (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; honoured only in IDLE, DONE or FAIL
rom_addr  out  ADDR_WIDTH  ROM read address, equals internal index register
rom_q  in  24  ROM data, valid one cycle after rom_addr is presented
wr_req  out  1  one-cycle write request pulse to SCCB master
wr_reg_addr  out  16  register address, stable from wr_req until wr_done
wr_data  out  8  register data, stable from wr_req until wr_done
wr_done  in  1  one-cycle completion pulse from SCCB master
wr_err  in  1  NACK flag, sampled only when wr_done=1
busy  out  1  high in every state except IDLE, DONE and FAIL
init_done  out  1  high in DONE only
init_err  out  1  high in FAIL only

Behaviour:
- Reset (asynchronous, any state, including mid-transfer): state=IDLE; index=0; delay counter=0; all outputs 0.
- States: IDLE, PWRUP, FETCH, LATCH, ISSUE, WAIT, RSTDLY, DONE, FAIL.
- IDLE/DONE/FAIL + start: clear init_done/init_err, index=0, load the counter with PWRUP_DELAY_CYC, go to PWRUP.
- PWRUP: decrement each cycle; when counter==1 go to FETCH. The first fetch occurs exactly PWRUP_DELAY_CYC cycles after start.
- FETCH: rom_addr=index; the ROM captures it on this edge.
- LATCH: register wr_reg_addr=rom_q[23:8] and wr_data=rom_q[7:0].
- ISSUE: wr_req=1 for exactly one cycle. It rises 3 cycles after FETCH is entered. Then go to WAIT.
- WAIT: hold address and data until wr_done.
  - wr_done & !wr_err & software-reset write (wr_reg_addr==16'h3008 and wr_data[7]==1): load RESET_DELAY_CYC, go to RSTDLY.
  - wr_done & !wr_err, any other entry: advance.
  - wr_done & wr_err: go to FAIL. index freezes at the failing entry for debug.
- RSTDLY: count down as in PWRUP, then advance.
- Advance: if index==REG_NUM-1, go to DONE and set index=0; else index+1, go to FETCH.
- start while busy is ignored. wr_done outside WAIT is ignored. A wr_done in the same cycle as a reset is lost.
- Counter width is $clog2(max(PWRUP_DELAY_CYC, RESET_DELAY_CYC)+1). A delay of 0 is treated as 1 cycle.
- No timeout on wr_done; the SCCB master guarantees completion.

Optional Feature:
OV5640_INIT_RETRY_EN
- Defined: per-entry retry counter, cleared on each FETCH from advance. On wr_done&wr_err with retries<MAX_RETRY, increment the counter and return to ISSUE with the same address and data. Once retries reach MAX_RETRY, go to FAIL.
- Undefined: the first NACK goes straight to FAIL; no retry logic is synthesised.

Decomposition:
- Package ov5640_init_pkg holds:
  - state enum
  - SW_RESET_REG=16'h3008 and SW_RESET_BIT=7
  - entry field slicing constants REG_ADDR_MSB=23, REG_ADDR_LSB=8, DATA_MSB=7
- Sub-module ov5640_delay_timer: loadable down-counter with load, load_val and expired outputs, shared by PWRUP and RSTDLY.

Test Plan:
All scenarios use REG_NUM=4, PWRUP_DELAY_CYC=10, RESET_DELAY_CYC=5, a stub ROM with entries {3103_11, 3008_82, 3008_42, 4300_00}, and an SCCB stub that answers wr_done 4 cycles after each wr_req.
- Normal run: start pulse → first wr_req 13 cycles after start with addr 3103, data 11; four writes in ROM order; RSTDLY of 5 cycles only after 3008_82; init_done=1, busy=0 afterwards.
- NACK on entry 2 (optional feature off) → init_err=1, rom_addr=2, no further wr_req, busy=0.
- NACK on entry 2 twice, then ack (feature on) → three wr_req with 3008_42, run completes, init_done=1. Four NACKs → init_err=1.
- start pulses while busy → no restart, write count stays 4. start in DONE → init_done drops, full sequence reruns.
- rst_n low during WAIT of entry 1 → outputs zero immediately; after release, start gives a clean run from entry 0.
- Stall: SCCB stub delays wr_done by 1000 cycles → wr_reg_addr and wr_data stay stable, exactly one wr_req per entry.

Source files
------------

// File: rtl/ov5640_init_pkg.sv
// Shared types and constants for the OV5640 init sequencer: FSM states,
// software-reset register identity and ROM entry field positions.
package ov5640_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_RSTDLY,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [15:0] SW_RESET_REG = 16'h3008;
    localparam int          SW_RESET_BIT = 7;

    // ROM entry layout: {reg_addr[15:0], data[7:0]}
    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;
    localparam int DATA_MSB     = 7;

    function automatic logic is_sw_reset(input logic [15:0] reg_addr, input logic [7:0] data);
        return (reg_addr == SW_RESET_REG) && data[SW_RESET_BIT];
    endfunction

endpackage

// File: rtl/ov5640_delay_timer.sv
// Loadable down-counter shared by the power-up and post-software-reset waits.
// expired_o is high while the count is 1 or 0, so a load of 0 behaves as 1.
module ov5640_delay_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/ov5640_init_seq.sv
// Walks the OV5640 init ROM and issues one SCCB write per entry, with power-up
// and software-reset settle delays. Optional NACK retry: OV5640_INIT_RETRY_EN.
module ov5640_init_seq
    import ov5640_init_pkg::*;
#(
    parameter int REG_NUM         = 252,
    parameter int ADDR_WIDTH      = 8,
    parameter int PWRUP_DELAY_CYC = 1000000,
    parameter int RESET_DELAY_CYC = 250000,
    parameter int MAX_RETRY       = 3,
    localparam int RETRY_W        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_err,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err,
    output state_t                dbg_state,
    output logic [RETRY_W-1:0]    dbg_retry
);

    localparam int MAX_DLY = (PWRUP_DELAY_CYC > RESET_DELAY_CYC) ? PWRUP_DELAY_CYC : RESET_DELAY_CYC;
    localparam int CNT_W   = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_NUM - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [15:0]           wr_reg_addr_q;
    logic [7:0]            wr_data_q;
    logic                  wr_req_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  start_ok;
    logic                  wait_ack;
    logic                  sw_reset_ack;
    logic                  advance;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_load_val;
    logic                  tmr_expired;

    // Handshake: wr_req is a single-cycle pulse; address/data hold until the
    // master returns a single-cycle wr_done, with wr_err qualifying it as NACK.
    assign start_ok     = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);
    assign wait_ack     = (state_q == ST_WAIT) && wr_done && !wr_err;
    assign sw_reset_ack = wait_ack && is_sw_reset(wr_reg_addr_q, wr_data_q);
    assign advance      = (wait_ack && !sw_reset_ack) || ((state_q == ST_RSTDLY) && tmr_expired);

    // Timer loads on the same edge the FSM enters PWRUP or RSTDLY.
    assign tmr_load     = start_ok || sw_reset_ack;
    assign tmr_load_val = start_ok ? CNT_W'(PWRUP_DELAY_CYC) : CNT_W'(RESET_DELAY_CYC);

    ov5640_delay_timer #(
        .CNT_W(CNT_W)
    ) u_delay_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .expired_o (tmr_expired)
    );

`ifdef OV5640_INIT_RETRY_EN
    logic [RETRY_W-1:0] retry_q;
    logic               retry_ok;

    assign retry_ok  = retry_q < RETRY_W'(MAX_RETRY);
    assign dbg_retry = retry_q;
`else
    assign dbg_retry = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            wr_reg_addr_q <= '0;
            wr_data_q     <= '0;
            wr_req_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
            retry_q       <= '0;
`endif
        end else begin
            wr_req_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_ok) begin
                        state_q <= ST_PWRUP;
                        index_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
                        retry_q <= '0;
`endif
                    end
                end
                ST_PWRUP: begin
                    if (tmr_expired) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    wr_reg_addr_q <= rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
                    wr_data_q     <= rom_q[DATA_MSB:0];
                    state_q       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    wr_req_q <= 1'b1;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wr_done && wr_err) begin
`ifdef OV5640_INIT_RETRY_EN
                        if (retry_ok) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_FAIL;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
`else
                        state_q <= ST_FAIL;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
`endif
                    end else if (sw_reset_ack) begin
                        state_q <= ST_RSTDLY;
                    end
                end
                ST_RSTDLY: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Common exit from WAIT (plain ack) and RSTDLY (delay expired).
            if (advance) begin
`ifdef OV5640_INIT_RETRY_EN
                retry_q <= '0;
`endif
                if (index_q == LAST_IDX) begin
                    state_q <= ST_DONE;
                    index_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_FETCH;
                    index_q <= index_q + 1'b1;
                end
            end
        end
    end

    assign rom_addr    = index_q;
    assign wr_req      = wr_req_q;
    assign wr_reg_addr = wr_reg_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign init_done   = done_q;
    assign init_err    = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Directed bench for ov5640_init_seq: stub ROM, SCCB stub with scoreboard,
// normal run, restart, NACK handling, async reset mid-write and long stall.
module tb_ov5640_init_seq;
  import ov5640_init_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_q = 24'h0;
  logic          wr_req;
  logic [15:0]   wr_reg_addr;
  logic [7:0]    wr_data;
  logic          wr_done = 1'b0;
  logic          wr_err = 1'b0;
  logic          busy;
  logic          init_done;
  logic          init_err;
  state_t        dbg_state;
  logic [1:0]    dbg_retry;

  ov5640_init_seq #(
    .REG_NUM(4),
    .ADDR_WIDTH(AW),
    .PWRUP_DELAY_CYC(10),
    .RESET_DELAY_CYC(5),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .wr_req(wr_req),
    .wr_reg_addr(wr_reg_addr),
    .wr_data(wr_data),
    .wr_done(wr_done),
    .wr_err(wr_err),
    .busy(busy),
    .init_done(init_done),
    .init_err(init_err),
    .dbg_state(dbg_state),
    .dbg_retry(dbg_retry)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stub ROM, one-cycle registered read
  logic [23:0] rom_mem [4] = '{24'h310311, 24'h300882, 24'h300842, 24'h430000};
  always @(posedge clk) rom_q <= (rom_addr < 8'd4) ? rom_mem[rom_addr[1:0]] : 24'h0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [23:0] exp_q[$];
  int          t_q[$];
  int          exp_t[4] = '{13, 20, 32, 39};
  int          start_cyc = 0;
  int          ack_dly = 4;
  int          nack_idx = -1;
  int          nack_left = 0;
  int          wr_cnt = 0;
  int          stab_err = 0;
  logic [15:0] a_cap;
  logic [7:0]  d_cap;
  logic        nack_now;
  logic        aborted;

  // SCCB stub: answers ack_dly cycles after wr_req, checks hold stability
  always begin
    @(negedge clk);
    if (rst_n && wr_req) begin
      a_cap = wr_reg_addr;
      d_cap = wr_data;
      wr_cnt++;
      t_q.push_back(cyc - start_cyc);
      check("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_wr", {8'h0, a_cap, d_cap}, {8'h0, exp_q.pop_front()});
      nack_now = (int'(rom_addr) == nack_idx) && (nack_left > 0);
      if (nack_now) nack_left--;
      aborted = 1'b0;
      repeat (ack_dly - 1) begin
        @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        if (!aborted && (wr_reg_addr !== a_cap || wr_data !== d_cap || wr_req !== 1'b0)) stab_err++;
      end
      if (!aborted && rst_n) begin
        wr_done = 1'b1;
        wr_err = nack_now;
        @(negedge clk);
        wr_done = 1'b0;
        wr_err = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input bit mark);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (mark) start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic push_entry(input int idx);
    exp_q.push_back(rom_mem[idx]);
  endtask

  task automatic load_normal();
    for (int i = 0; i < 4; i++) push_entry(i);
  endtask

  task automatic clear_run();
    exp_q.delete();
    t_q.delete();
    wr_cnt = 0;
    stab_err = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_times(input string tag);
    check({tag, "_nwr"}, 32'(t_q.size()), 32'd4);
    if (t_q.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("%s_t%0d", tag, i), 32'(t_q[i]), 32'(exp_t[i]));
  endtask

  task automatic check_done(input string tag, input int nwr);
    check({tag, "_done"}, 32'(init_done), 32'd1);
    check({tag, "_err"}, 32'(init_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wrcnt"}, 32'(wr_cnt), 32'(nwr));
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idx"}, 32'(rom_addr), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(init_done), 32'd0);
    check({tag, "_err"}, 32'(init_err), 32'd0);
    check({tag, "_wr_req"}, 32'(wr_req), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_addr"}, 32'(wr_reg_addr), 32'd0);
    check({tag, "_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // normal run
    clear_run();
    load_normal();
    pulse_start(1'b1);
    wait_idle(200);
    check_done("run1", 4);
    check_times("run1");

    // restart from DONE with start pulses while busy
    clear_run();
    load_normal();
    pulse_start(1'b1);
    check("rerun_done_drop", 32'(init_done), 32'd0);
    check("rerun_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    pulse_start(1'b0);
    repeat (18) @(negedge clk);
    pulse_start(1'b0);
    wait_idle(200);
    check_done("run2", 4);
    check_times("run2");

    // NACK on entry 2
`ifdef OV5640_INIT_RETRY_EN
    clear_run();
    for (int i = 0; i < 3; i++) push_entry(i);
    push_entry(2);
    push_entry(2);
    push_entry(3);
    nack_idx = 2;
    nack_left = 2;
    pulse_start(1'b1);
    wait_idle(300);
    check_done("retry_ok", 6);

    clear_run();
    for (int i = 0; i < 3; i++) push_entry(i);
    for (int i = 0; i < 3; i++) push_entry(2);
    nack_left = 4;
    pulse_start(1'b1);
    wait_idle(300);
    check("retry_fail_err", 32'(init_err), 32'd1);
    check("retry_fail_done", 32'(init_done), 32'd0);
    check("retry_fail_idx", 32'(rom_addr), 32'd2);
    check("retry_fail_wrcnt", 32'(wr_cnt), 32'd6);
`else
    clear_run();
    for (int i = 0; i < 3; i++) push_entry(i);
    nack_idx = 2;
    nack_left = 1;
    pulse_start(1'b1);
    wait_idle(300);
    check("nack_err", 32'(init_err), 32'd1);
    check("nack_done", 32'(init_done), 32'd0);
    check("nack_idx", 32'(rom_addr), 32'd2);
    check("nack_wrcnt", 32'(wr_cnt), 32'd3);
    repeat (30) @(negedge clk);
    check("nack_no_more_wr", 32'(wr_cnt), 32'd3);
    check("nack_sb_left", 32'(exp_q.size()), 32'd0);
`endif
    nack_idx = -1;
    nack_left = 0;

    // async reset during WAIT of entry 1
    clear_run();
    load_normal();
    pulse_start(1'b1);
    n = 0;
    while (wr_cnt < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_wait", 32'(wr_cnt), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    clear_run();
    load_normal();
    pulse_start(1'b1);
    wait_idle(200);
    check_done("postrst", 4);
    check_times("postrst");

    // long wr_done stall
    clear_run();
    load_normal();
    ack_dly = 1000;
    pulse_start(1'b1);
    wait_idle(6000);
    check_done("stall", 4);
    check("stall_stable", 32'(stab_err), 32'd0);
    ack_dly = 4;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
